car_scheduler: RTL and testbench

CAR_SCHEDULER -- requirements
Module: car_scheduler

---
 rtl/car_scheduler.sv | 227 ++++++++++++++++++++++
 tb/tb_car_scheduler.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/car_scheduler.sv
// car_scheduler
//   Frame-paced draw scheduler for a set of car controllers. A stage begins on
//   start_stage. Once per animation frame the scheduler walks the cars in index
//   order and grants a one-cycle draw slot to each car that is alive and
//   waiting. It then waits for that car to finish drawing before it moves to
//   the next index. The stage ends when every car reports destroyed.
//
//   Optional build macro: SCHED_TIMEOUT_EN adds a watchdog that abandons a car
//   after TIMEOUT_TICKS cycles in SERVICE and sets the sticky svc_timeout flag.
//   Without the macro, SERVICE waits indefinitely and svc_timeout is tied low.
//
// Ports
//   clk                  system clock, rising edge
//   resetn               synchronous active-low reset
//   start_stage          begin a stage (sampled only in IDLE)
//   car_draw_wait[N]     per-car "idle, awaiting draw grant"
//   car_destroyed_state[N] per-car destroyed status
//   initiate             stage-active level broadcast to all cars
//   enable_draw[N]       one-hot, one-cycle draw grant
//   stage_done           one-cycle pulse when all cars are destroyed
//   busy                 high in every state except IDLE
//   cars_left[4]         registered count of cars still alive
//   frame_overrun        sticky: a frame boundary arrived while one was pending
//   svc_timeout          sticky watchdog flag (SCHED_TIMEOUT_EN builds only)
//
// State table
//   IDLE       | waiting for start_stage, everything quiet
//   LAUNCH     | one cycle: raise initiate, clear frame/overrun/timeout state
//   FRAME_WAIT | waiting for the next frame boundary
//   SCAN       | test car idx; skip it or grant it
//   GRANT      | one-cycle enable_draw to car idx
//   SERVICE    | wait for car idx to take and finish its draw
//   DONE       | one-cycle stage_done, initiate dropped

module car_scheduler #(
  parameter int NUM_CARS      = 4,
  parameter int FRAME_TICKS   = 833333,
  parameter int TIMEOUT_TICKS = 4096
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                start_stage,
  input  logic [NUM_CARS-1:0] car_draw_wait,
  input  logic [NUM_CARS-1:0] car_destroyed_state,
  output logic                initiate,
  output logic [NUM_CARS-1:0] enable_draw,
  output logic                stage_done,
  output logic                busy,
  output logic [3:0]          cars_left,
  output logic                frame_overrun,
  output logic                svc_timeout
);

  localparam int IDX_W = (NUM_CARS > 1) ? $clog2(NUM_CARS) : 1;
  localparam int FRM_W = $clog2(FRAME_TICKS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CARS - 1);
  localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(FRAME_TICKS - 1);

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    FRAME_WAIT,
    SCAN,
    GRANT,
    SERVICE,
    DONE
  } state_t;

  state_t           state, state_n;
  logic [IDX_W-1:0] idx, idx_n;
  logic [FRM_W-1:0] frame_cnt;
  logic             frame_pending;
  logic             frame_run;
  logic             frame_tc;
  logic             pending_clr;
  logic             svc_fell, svc_fell_n;
  logic             svc_expired;
  logic             all_destroyed;
  logic             cur_wait;
  logic             cur_dead;
  logic             adv;
  logic [3:0]       alive_cnt;

  assign all_destroyed = &car_destroyed_state;
  assign cur_wait      = car_draw_wait[idx];
  assign cur_dead      = car_destroyed_state[idx];

  // The frame counter is held in IDLE and DONE. LAUNCH reloads it, so it counts
  // in every other state.
  assign frame_run = (state != IDLE) && (state != DONE) && (state != LAUNCH);
  assign frame_tc  = frame_run && (frame_cnt == FRM_LAST);

  assign initiate   = (state != IDLE) && (state != DONE);
  assign busy       = (state != IDLE);
  assign stage_done = (state == DONE);

  always_comb begin
    enable_draw = '0;
    if (state == GRANT) enable_draw[idx] = 1'b1;
  end

  always_comb begin
    alive_cnt = '0;
    for (int i = 0; i < NUM_CARS; i++)
      alive_cnt = alive_cnt + {3'b000, ~car_destroyed_state[i]};
  end

  // Watchdog: counts SERVICE cycles. It expires on the TIMEOUT_TICKS-th
  // cycle spent with one car.
`ifdef SCHED_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_TICKS - 1);

  logic [TMO_W-1:0] svc_cnt;
  logic             svc_timeout_q;

  assign svc_expired = (state == SERVICE) && (svc_cnt == TMO_LAST);
  assign svc_timeout = svc_timeout_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      svc_cnt       <= '0;
      svc_timeout_q <= 1'b0;
    end else begin
      if (state == LAUNCH)  svc_timeout_q <= 1'b0;
      else if (svc_expired) svc_timeout_q <= 1'b1;
      if (state == SERVICE) svc_cnt <= svc_cnt + 1'b1;
      else                  svc_cnt <= '0;
    end
  end
`else
  assign svc_expired = 1'b0;
  assign svc_timeout = 1'b0;
`endif

  always_comb begin
    state_n     = state;
    idx_n       = idx;
    svc_fell_n  = svc_fell;
    pending_clr = 1'b0;
    adv         = 1'b0;

    unique case (state)
      IDLE: begin
        if (start_stage) state_n = LAUNCH;
      end
      LAUNCH: begin
        idx_n   = '0;
        state_n = FRAME_WAIT;
      end
      FRAME_WAIT: begin
        if (frame_pending) begin
          pending_clr = 1'b1;
          idx_n       = '0;
          state_n     = SCAN;
        end
      end
      SCAN: begin
        if (cur_dead || !cur_wait) adv = 1'b1;
        else                       state_n = GRANT;
      end
      GRANT: begin
        svc_fell_n = 1'b0;
        state_n    = SERVICE;
      end
      SERVICE: begin
        // A car is finished once it has dropped draw_wait and then either
        // raised it again or been destroyed.
        if (!svc_fell) begin
          if (!cur_wait) svc_fell_n = 1'b1;
        end else if (cur_wait || cur_dead) begin
          adv = 1'b1;
        end
        if (svc_expired) adv = 1'b1;
      end
      DONE: begin
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    // Moving past the last index ends the frame. The stage ends too if no car
    // is left alive.
    if (adv) begin
      if (idx == LAST_IDX) begin
        idx_n   = '0;
        state_n = all_destroyed ? DONE : FRAME_WAIT;
      end else begin
        idx_n   = idx + 1'b1;
        state_n = SCAN;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state         <= IDLE;
      idx           <= '0;
      svc_fell      <= 1'b0;
      frame_cnt     <= '0;
      frame_pending <= 1'b0;
      frame_overrun <= 1'b0;
      cars_left     <= 4'(NUM_CARS);
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      svc_fell  <= svc_fell_n;
      cars_left <= alive_cnt;

      if (state == LAUNCH) begin
        frame_cnt     <= '0;
        frame_pending <= 1'b0;
        frame_overrun <= 1'b0;
      end else if (frame_run) begin
        frame_cnt <= frame_tc ? '0 : frame_cnt + 1'b1;
        // A new boundary wins over a same-cycle clear, so no frame is lost.
        if (frame_tc) begin
          frame_pending <= 1'b1;
          if (frame_pending) frame_overrun <= 1'b1;
        end else if (pending_clr) begin
          frame_pending <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_car_scheduler.sv
// tb_car_scheduler
//   Self-checking bench for car_scheduler with NUM_CARS=4, FRAME_TICKS=16 and
//   TIMEOUT_TICKS=64. Behavioural car models answer draw grants. The bench
//   pushes expected grant indices into a queue, and the monitor pops and
//   compares one entry for each grant it sees. Define SCHED_TIMEOUT_EN for
//   both the DUT and the bench to exercise the watchdog.

module tb_car_scheduler;

  localparam int NUM_CARS      = 4;
  localparam int FRAME_TICKS   = 16;
  localparam int TIMEOUT_TICKS = 64;

  logic                clk = 1'b0;
  logic                resetn;
  logic                start_stage;
  logic [NUM_CARS-1:0] car_draw_wait;
  logic [NUM_CARS-1:0] car_destroyed_state;
  logic                initiate;
  logic [NUM_CARS-1:0] enable_draw;
  logic                stage_done;
  logic                busy;
  logic [3:0]          cars_left;
  logic                frame_overrun;
  logic                svc_timeout;

  always #5 clk = ~clk;

  car_scheduler #(
    .NUM_CARS      (NUM_CARS),
    .FRAME_TICKS   (FRAME_TICKS),
    .TIMEOUT_TICKS (TIMEOUT_TICKS)
  ) dut (
    .clk                 (clk),
    .resetn              (resetn),
    .start_stage         (start_stage),
    .car_draw_wait       (car_draw_wait),
    .car_destroyed_state (car_destroyed_state),
    .initiate            (initiate),
    .enable_draw         (enable_draw),
    .stage_done          (stage_done),
    .busy                (busy),
    .cars_left           (cars_left),
    .frame_overrun       (frame_overrun),
    .svc_timeout         (svc_timeout)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int exp_q[$];
  int n_grants = 0;
  int n_done   = 0;

  // Car model configuration. waiting: idle draw_wait level. respond: the car
  // drops draw_wait after a grant. hold: cycles that draw_wait stays low.
  logic [NUM_CARS-1:0] waiting;
  logic [NUM_CARS-1:0] respond;
  int hold  [NUM_CARS];
  int phase [NUM_CARS];
  int tmr   [NUM_CARS];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic int onehot_idx(input logic [NUM_CARS-1:0] v);
    for (int i = 0; i < NUM_CARS; i++)
      if (v[i]) return i;
    return -1;
  endfunction

  // Monitor and car models. Everything here happens on the falling edge, away
  // from the DUT's active edge.
  always @(negedge clk) begin
    if (resetn === 1'b1) begin
      if (enable_draw != '0) begin
        n_grants++;
        check_val("grant_onehot", $countones(enable_draw), 1);
        if (exp_q.size() == 0) check_val("grant_unexpected", onehot_idx(enable_draw), -1);
        else                   check_val("grant_order", onehot_idx(enable_draw), exp_q.pop_front());
      end
      if (stage_done === 1'b1) begin
        n_done++;
        check_val("done_initiate_low", initiate, 0);
      end
    end
    for (int i = 0; i < NUM_CARS; i++) begin
      if (resetn !== 1'b1) begin
        phase[i] = 0;
        car_draw_wait[i] = waiting[i];
      end else begin
        case (phase[i])
          0: begin
            car_draw_wait[i] = waiting[i];
            if (enable_draw[i] && respond[i]) phase[i] = 1;
          end
          1: begin
            car_draw_wait[i] = 1'b0;
            tmr[i] = hold[i];
            phase[i] = 2;
          end
          default: begin
            tmr[i]--;
            if (tmr[i] <= 0) begin
              car_draw_wait[i] = 1'b1;
              phase[i] = 0;
            end
          end
        endcase
      end
    end
  end

  task automatic wait_grant(input int budget, output int k);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (enable_draw == '0 && k < budget);
    if (enable_draw == '0) check_val("grant_wait_expired", 0, 1);
  endtask

  task automatic wait_grants(input int target, input int budget, input string tag);
    int c = 0;
    while (n_grants < target && c < budget) begin
      @(negedge clk);
      c++;
    end
    check_val(tag, (n_grants >= target), 1);
  endtask

  task automatic wait_done(input int budget);
    int c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (stage_done !== 1'b1 && c < budget);
    check_val("stage_done_seen", stage_done, 1);
  endtask

  task automatic pulse_start();
    start_stage = 1'b1;
    @(negedge clk);
    start_stage = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_time_limit: got expired, expected finish");
    $fatal(1, "time limit");
  end

  initial begin
    int k;
    int g0;
    resetn = 1'b0;
    start_stage = 1'b0;
    car_destroyed_state = 4'b0100;
    waiting = 4'hF;
    respond = 4'hF;
    for (int i = 0; i < NUM_CARS; i++) hold[i] = 5;

    // Reset values; cars_left must ignore the destroyed car while in reset.
    repeat (3) @(negedge clk);
    check_val("rst_initiate", initiate, 0);
    check_val("rst_enable_draw", enable_draw, 0);
    check_val("rst_stage_done", stage_done, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_overrun", frame_overrun, 0);
    check_val("rst_svc_timeout", svc_timeout, 0);
    check_val("rst_cars_left", cars_left, 4);
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    check_val("cars_left_one_dead", cars_left, 3);
    car_destroyed_state = 4'b0000;
    repeat (2) @(negedge clk);
    check_val("cars_left_all_alive", cars_left, 4);
    check_val("idle_busy", busy, 0);

    // Stage A: all cars serviced in order, two frames.
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NUM_CARS; i++) exp_q.push_back(i);
    pulse_start();
    check_val("launch_busy", busy, 1);
    check_val("launch_initiate", initiate, 1);
    check_val("launch_no_grant", enable_draw, 0);
    // Timeline: LAUNCH at S+1, the first boundary at S+17, pending seen in
    // FRAME_WAIT at S+18, SCAN at S+19 and GRANT at S+20.
    wait_grant(100, k);
    check_val("first_grant_lat", k, 19);
    wait_grants(8, 300, "two_frames_granted");

    // Car 2 destroyed: never granted again.
    car_destroyed_state = 4'b0100;
    for (int r = 0; r < 2; r++) begin
      exp_q.push_back(0);
      exp_q.push_back(1);
      exp_q.push_back(3);
    end
    wait_grants(14, 400, "skip_dead_granted");
    check_val("cars_left_three", cars_left, 3);

    // All destroyed. A start pulse while busy must be ignored.
    car_destroyed_state = 4'hF;
    pulse_start();
    wait_done(200);
    check_val("done_busy", busy, 1);
    @(negedge clk);
    check_val("after_done_pulse", stage_done, 0);
    check_val("after_done_busy", busy, 0);
    check_val("after_done_initiate", initiate, 0);
    check_val("after_done_cars_left", cars_left, 0);
    check_val("overrun_stage_a", frame_overrun, 1);
    repeat (5) @(negedge clk);
    check_val("start_ignored_busy", busy, 0);
    check_val("done_pulses_a", n_done, 1);

    // Stage B: only car 1 waits and it holds draw_wait low for 40 cycles.
    car_destroyed_state = 4'b0000;
    waiting = 4'b0010;
    hold[1] = 40;
    exp_q.push_back(1);
    pulse_start();
    check_val("launch_b_busy", busy, 1);
    @(negedge clk);
    check_val("overrun_clr_launch", frame_overrun, 0);
    wait_grant(100, k);
    check_val("grant_b_lat", k, 19);
    waiting[1] = 1'b0;
    check_val("overrun_before_long_hold", frame_overrun, 0);
    repeat (45) @(negedge clk);
    check_val("overrun_long_hold", frame_overrun, 1);
    car_destroyed_state = 4'hF;
    wait_done(200);
    @(negedge clk);
    check_val("overrun_sticky_idle", frame_overrun, 1);
    check_val("done_pulses_b", n_done, 2);

    // Stage C: car 0 never answers its grant.
    car_destroyed_state = 4'b0000;
    waiting = 4'b0011;
    respond = 4'b1110;
    hold[1] = 30;
    exp_q.push_back(0);
`ifdef SCHED_TIMEOUT_EN
    exp_q.push_back(1);
`endif
    pulse_start();
    wait_grant(100, k);
`ifdef SCHED_TIMEOUT_EN
    for (int j = 1; j <= 65; j++) begin
      @(negedge clk);
      if (j == 64) check_val("svc_timeout_early", svc_timeout, 0);
    end
    check_val("svc_timeout_set", svc_timeout, 1);
    wait_grant(10, k);
    check_val("tmo_next_grant", k, 1);
    repeat (5) @(negedge clk);
    check_val("svc_timeout_pre_rst", svc_timeout, 1);
`else
    @(negedge clk);
    g0 = n_grants;
    repeat (99) @(negedge clk);
    check_val("no_watchdog_flag", svc_timeout, 0);
    check_val("service_holds", n_grants, g0);
`endif
    check_val("overrun_pre_rst", frame_overrun, 1);
    check_val("busy_pre_rst", busy, 1);

    // Reset in the middle of SERVICE.
    car_destroyed_state = 4'b0100;
    resetn = 1'b0;
    @(negedge clk);
    check_val("mid_rst_initiate", initiate, 0);
    check_val("mid_rst_enable_draw", enable_draw, 0);
    check_val("mid_rst_stage_done", stage_done, 0);
    check_val("mid_rst_busy", busy, 0);
    check_val("mid_rst_overrun", frame_overrun, 0);
    check_val("mid_rst_svc_timeout", svc_timeout, 0);
    check_val("mid_rst_cars_left", cars_left, 4);
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    check_val("post_rst_cars_left", cars_left, 3);
    check_val("post_rst_busy", busy, 0);
    check_val("scoreboard_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
